// File: rtl/msrv32_instr_fetch_buffer.sv
// Fetch buffer between instruction memory and the instruction mux: small {pc,instr} FIFO with a registered output stage.
// Latency 2 edges from accept to output; ready drops when full, stall holds outputs; MSRV32_FETCH_MISALIGN_CHK_EN adds misalignment flagging.
module msrv32_instr_fetch_buffer #(
    parameter int          DEPTH      = 2,
    parameter int          KILL_WORDS = 1,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        instr_valid_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        instr_ready_out,
    input  logic        stall_in,
    input  logic        branch_flush_in,
    output logic [31:0] ms_riscv32_mp_instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        flush_out,
    output logic        instr_misaligned_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [3:0]    kill_cnt;
    logic          accept, push, pop;

    always_comb begin
        instr_ready_out = (count != CW'(DEPTH));
        accept          = instr_valid_in & instr_ready_out & ~branch_flush_in;
        push            = accept & (kill_cnt == 4'd0);
        pop             = ~branch_flush_in & ~stall_in & (count != '0);
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            instr_mem[wr_ptr] <= instr_in;
            pc_mem[wr_ptr]    <= pc_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            kill_cnt <= 4'd0;
        end else if (branch_flush_in) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            kill_cnt <= 4'(KILL_WORDS);
        end else begin
            if (accept && kill_cnt != 4'd0)
                kill_cnt <= kill_cnt - 4'd1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
    logic mis_mem [DEPTH];
    logic mis_q;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push)
            mis_mem[wr_ptr] <= (pc_in[1:0] != 2'b00);
    end

    // A misaligned head is presented as a valid NOP so the trap logic still sees its PC.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            ms_riscv32_mp_instr_out <= NOP_INSTR;
            pc_out                  <= '0;
            valid_out               <= 1'b0;
            mis_q                   <= 1'b0;
        end else if (branch_flush_in) begin
            ms_riscv32_mp_instr_out <= NOP_INSTR;
            valid_out               <= 1'b0;
            mis_q                   <= 1'b0;
        end else if (!stall_in) begin
            if (pop) begin
                ms_riscv32_mp_instr_out <= mis_mem[rd_ptr] ? NOP_INSTR : instr_mem[rd_ptr];
                pc_out                  <= pc_mem[rd_ptr];
                valid_out               <= 1'b1;
                mis_q                   <= mis_mem[rd_ptr];
            end else begin
                ms_riscv32_mp_instr_out <= NOP_INSTR;
                valid_out               <= 1'b0;
                mis_q                   <= 1'b0;
            end
        end
    end

    assign instr_misaligned_out = mis_q;
`else
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            ms_riscv32_mp_instr_out <= NOP_INSTR;
            pc_out                  <= '0;
            valid_out               <= 1'b0;
        end else if (branch_flush_in) begin
            ms_riscv32_mp_instr_out <= NOP_INSTR;
            valid_out               <= 1'b0;
        end else if (!stall_in) begin
            if (pop) begin
                ms_riscv32_mp_instr_out <= instr_mem[rd_ptr];
                pc_out                  <= pc_mem[rd_ptr];
                valid_out               <= 1'b1;
            end else begin
                ms_riscv32_mp_instr_out <= NOP_INSTR;
                valid_out               <= 1'b0;
            end
        end
    end

    assign instr_misaligned_out = 1'b0;
`endif

    assign flush_out = ~valid_out;

endmodule

// File: tb/tb_msrv32_instr_fetch_buffer.sv
// Bench for msrv32_instr_fetch_buffer: directed scenarios with literal expectations, then random traffic against a queue model.
module tb_msrv32_instr_fetch_buffer;
    localparam int          DEPTH = 2;
    localparam int          KILL  = 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv = 1'b0, st = 1'b0, fl = 1'b0;
    logic [31:0] ii = '0, pi = '0;
    logic        rdy, vo, fo, mo;
    logic [31:0] io, po;

    msrv32_instr_fetch_buffer #(.DEPTH(DEPTH), .KILL_WORDS(KILL), .NOP_INSTR(NOP)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .instr_valid_in         (iv),
        .instr_in               (ii),
        .pc_in                  (pi),
        .instr_ready_out        (rdy),
        .stall_in               (st),
        .branch_flush_in        (fl),
        .ms_riscv32_mp_instr_out(io),
        .pc_out                 (po),
        .valid_out              (vo),
        .flush_out              (fo),
        .instr_misaligned_out   (mo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } ent_t;

    ent_t        q[$];
    int          kill;
    logic [31:0] m_instr, m_pc;
    logic        m_valid, m_mis;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        kill    = 0;
        m_instr = NOP;
        m_pc    = '0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    // One clock edge of the buffer described at queue level.
    task automatic model_step();
        bit   room;
        bit   acc;
        ent_t e;
        room = (q.size() != DEPTH);
        acc  = iv && room && !fl;
        if (fl) begin
            q.delete();
            kill    = KILL;
            m_instr = NOP;
            m_valid = 1'b0;
            m_mis   = 1'b0;
        end else begin
            if (!st) begin
                if (q.size() > 0) begin
                    e       = q.pop_front();
                    m_instr = e.mis ? NOP : e.instr;
                    m_pc    = e.pc;
                    m_valid = 1'b1;
                    m_mis   = e.mis;
                end else begin
                    m_instr = NOP;
                    m_valid = 1'b0;
                    m_mis   = 1'b0;
                end
            end
            if (acc) begin
                if (kill > 0) kill--;
                else begin
                    e.instr = ii;
                    e.pc    = pi;
`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
                    e.mis   = (pi[1:0] != 2'b00);
`else
                    e.mis   = 1'b0;
`endif
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("instr", io, m_instr);
        chk("pc", po, m_pc);
        chk("valid", 32'(vo), 32'(m_valid));
        chk("flush", 32'(fo), 32'(!m_valid));
        chk("misaligned", 32'(mo), 32'(m_mis));
    endtask

    // Called at a negedge: drive, step across the posedge, compare at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic s, input logic f);
        iv = v; ii = i; pi = p; st = s; fl = f;
        #1;
        if (rst_n) chk("ready", 32'(rdy), 32'(q.size() != DEPTH));
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic lit(input string name, input logic v, input logic [31:0] i, input logic [31:0] p);
        chk({name, "_valid"}, 32'(vo), 32'(v));
        chk({name, "_flush"}, 32'(fo), 32'(!v));
        chk({name, "_instr"}, io, i);
        chk({name, "_pc"}, po, p);
    endtask

    initial begin
        // Reset with a valid response pending.
        rst_n = 1'b0; iv = 1'b1; ii = 32'hdead_beef; pi = 32'h4;
        model_reset();
        repeat (3) @(negedge clk);
        lit("rst", 1'b0, NOP, 32'h0);
        chk("rst_mis", 32'(mo), 32'h0);
        rst_n = 1'b1; iv = 1'b0;
        #1;
        chk("rst_rdy", 32'(rdy), 32'h1);
        @(negedge clk);

        // Back-to-back stream.
        cycle(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
        lit("s0", 1'b0, NOP, 32'h0);
        cycle(1'b1, 32'h0010_0113, 32'h4, 1'b0, 1'b0);
        lit("s1", 1'b1, 32'h0050_0093, 32'h0);
        cycle(1'b1, 32'h0020_81B3, 32'h8, 1'b0, 1'b0);
        lit("s2", 1'b1, 32'h0010_0113, 32'h4);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lit("s3", 1'b1, 32'h0020_81B3, 32'h8);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lit("s4", 1'b0, NOP, 32'h8);

        // Stall 4 cycles while 3 words are offered.
        cycle(1'b1, 32'hAAAA_0001, 32'h10, 1'b1, 1'b0);
        cycle(1'b1, 32'hAAAA_0002, 32'h14, 1'b1, 1'b0);
        chk("stall_full_rdy", 32'(rdy), 32'h0);
        cycle(1'b1, 32'hAAAA_0003, 32'h18, 1'b1, 1'b0);
        cycle(1'b1, 32'hAAAA_0003, 32'h18, 1'b1, 1'b0);
        lit("stall_hold", 1'b0, NOP, 32'h8);
        cycle(1'b1, 32'hAAAA_0003, 32'h18, 1'b0, 1'b0);
        lit("st0", 1'b1, 32'hAAAA_0001, 32'h10);
        cycle(1'b1, 32'hAAAA_0003, 32'h18, 1'b0, 1'b0);
        lit("st1", 1'b1, 32'hAAAA_0002, 32'h14);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lit("st2", 1'b1, 32'hAAAA_0003, 32'h18);

        // Redirect with two buffered words, then one killed response.
        cycle(1'b1, 32'hBBBB_0001, 32'h20, 1'b1, 1'b0);
        cycle(1'b1, 32'hBBBB_0002, 32'h24, 1'b1, 1'b0);
        cycle(1'b1, 32'hBBBB_0003, 32'h28, 1'b0, 1'b1);
        lit("fl0", 1'b0, NOP, 32'h18);
        cycle(1'b1, 32'h1111_1111, 32'h30, 1'b0, 1'b0);
        lit("fl1", 1'b0, NOP, 32'h18);
        cycle(1'b1, 32'h1234_5678, 32'h40, 1'b0, 1'b0);
        lit("fl2", 1'b0, NOP, 32'h18);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lit("fl3", 1'b1, 32'h1234_5678, 32'h40);

        // Flush and stall together on a full FIFO: flush wins.
        cycle(1'b1, 32'hCCCC_0001, 32'h50, 1'b1, 1'b0);
        cycle(1'b1, 32'hCCCC_0002, 32'h54, 1'b1, 1'b0);
        lit("fs_hold", 1'b1, 32'h1234_5678, 32'h40);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        lit("fs0", 1'b0, NOP, 32'h40);
        chk("fs_rdy", 32'(rdy), 32'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lit("fs1", 1'b0, NOP, 32'h40);

        // Misaligned PC (first response after the redirect is killed).
        cycle(1'b1, 32'hDEAD_BEEF, 32'h60, 1'b0, 1'b0);
        cycle(1'b1, 32'h0050_0093, 32'h102, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
        lit("mis", 1'b1, NOP, 32'h102);
        chk("mis_flag", 32'(mo), 32'h1);
`else
        lit("mis", 1'b1, 32'h0050_0093, 32'h102);
        chk("mis_flag", 32'(mo), 32'h0);
`endif

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
